// File: rtl/ones_pkg.sv
// Shared types and constants for the ones-count arbiter slice.
package ones_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ACC_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESP  = 2'd2
  } stateT;

  // Width needed to hold a count from 0 up to and including dataW.
  function automatic int cntWidth(input int dataW);
    return $clog2(dataW + 1);
  endfunction

endpackage

// File: rtl/ones_counter.sv
// Combinational population count; the single shared datapath behind the arbiter.
module ones_counter
  import ones_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = cntWidth(DEF_DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  // Sum of the individual bits of the word.
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter sharing one popcount unit between NUM_REQ requesters.
// Optional per-requester saturating running totals: define ONES_ACC_EN.
module ones_count_arbiter
  import ones_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          res_valid,
  output logic [cntWidth(DATA_W)-1:0] res_count,
  input  logic [NUM_REQ-1:0]          res_ready,
  output logic                        busy
`ifdef ONES_ACC_EN
  ,
  input  logic [NUM_REQ-1:0]          acc_clr,
  output logic [NUM_REQ*ACC_W-1:0]    acc_total
`endif
);

  localparam int CNT_W = cntWidth(DATA_W);
  localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  stateT              stateR;
  stateT              stateNextS;
  logic [GW-1:0]      lastGrantR;
  logic [GW-1:0]      grantR;
  logic [DATA_W-1:0]  dataR;
  logic [CNT_W-1:0]   countR;
  logic [CNT_W-1:0]   popS;
  logic [GW-1:0]      pickS;
  logic               anyValidS;
  logic [DATA_W-1:0]  selDataS;
  logic [NUM_REQ-1:0] reqReadyS;
  logic [NUM_REQ-1:0] resValidS;

  // First valid requester after `last`, wrapping; `last` itself has lowest priority.
  function automatic logic [GW-1:0] rrPick(input logic [NUM_REQ-1:0] valid,
                                           input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    int            idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (valid[idx]) begin
        pick = GW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign anyValidS = |req_valid;
  assign pickS     = rrPick(req_valid, lastGrantR);

  // Mux the granted requester's word toward the capture register.
  always_comb begin
    selDataS = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      selDataS = selDataS | (req_data[i*DATA_W +: DATA_W] & {DATA_W{pickS == GW'(i)}});
    end
  end

  ones_counter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) uCounter (
    .data  (dataR),
    .count (popS)
  );

  // Next-state and accept strobe; acceptance only from IDLE and never while in reset.
  always_comb begin
    stateNextS = stateR;
    reqReadyS  = '0;
    case (stateR)
      IDLE: begin
        if (anyValidS && !rst) begin
          stateNextS       = COUNT;
          reqReadyS[pickS] = 1'b1;
        end else begin
          stateNextS = IDLE;
        end
      end
      COUNT: stateNextS = RESP;
      RESP: begin
        if (res_ready[grantR]) begin
          stateNextS = IDLE;
        end else begin
          stateNextS = RESP;
        end
      end
      default: stateNextS = IDLE;
    endcase
  end

  // State, grant bookkeeping and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR     <= IDLE;
      lastGrantR <= GW'(NUM_REQ - 1);
      grantR     <= '0;
      dataR      <= '0;
      countR     <= '0;
    end else begin
      stateR <= stateNextS;
      case (stateR)
        IDLE: begin
          if (anyValidS) begin
            grantR <= pickS;
            dataR  <= selDataS;
          end
        end
        COUNT: countR <= popS;
        RESP: begin
          if (res_ready[grantR]) begin
            lastGrantR <= grantR;
          end
        end
        default: ;
      endcase
    end
  end

  // Result valid is a decode of registered state and grant only.
  always_comb begin
    resValidS = '0;
    if (stateR == RESP) begin
      resValidS[grantR] = 1'b1;
    end else begin
      resValidS = '0;
    end
  end

  assign req_ready = reqReadyS;
  assign res_valid = resValidS;
  assign res_count = countR;
  assign busy      = (stateR != IDLE);

`ifdef ONES_ACC_EN
  logic [NUM_REQ-1:0][ACC_W-1:0] accR;
  logic [NUM_REQ-1:0][ACC_W-1:0] accNextS;
  logic [NUM_REQ-1:0][ACC_W:0]   sumS;
  logic [NUM_REQ-1:0]            hsS;

  // Clear happens before the add, so a coincident clear leaves just this result.
  always_comb begin
    accNextS = accR;
    sumS     = '0;
    hsS      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hsS[i]  = (stateR == RESP) && (grantR == GW'(i)) && res_ready[i];
      sumS[i] = {1'b0, (acc_clr[i] ? {ACC_W{1'b0}} : accR[i])} + (ACC_W+1)'(countR);
      if (hsS[i]) begin
        accNextS[i] = sumS[i][ACC_W] ? {ACC_W{1'b1}} : sumS[i][ACC_W-1:0];
      end else if (acc_clr[i]) begin
        accNextS[i] = '0;
      end else begin
        accNextS[i] = accR[i];
      end
    end
  end

  // Running-total registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      accR <= '0;
    end else begin
      accR <= accNextS;
    end
  end

  assign acc_total = accR;
`endif

endmodule
